// File: rtl/scan_decoder_nx2n.sv
// Registered N-to-2^N one-hot decoder with DIRECT (load/decode) and SCAN (auto-cycling) modes.
// Optional build macro SCAN_DEC_BLANK_EN blanks d during the last cycle of each scan dwell.
module scan_decoder_nx2n #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic            load,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] d,
    output logic [N-1:0]    idx,
    output logic            wrap
);
    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   d_q, d_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wrap_q, wrap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        wrap_d  = 1'b0;

        if (!en)       state_d = S_IDLE;
        else if (mode) state_d = S_SCAN;
        else           state_d = S_DIRECT;

        case (state_d)
            S_IDLE: d_d = '0;
            S_DIRECT: begin
                if (load) begin
                    d_d   = W'(1) << sel;
                    idx_d = sel;
                end else if (state_q != S_DIRECT) begin
                    d_d = '0;
                end
            end
            S_SCAN: begin
                if (state_q != S_SCAN) begin
                    // Every entry restarts the frame at output 0 with a full dwell.
                    d_d   = W'(1);
                    idx_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    d_d    = {d_q[W-2:0], d_q[W-1]};
                    idx_d  = idx_q + 1'b1;
                    wrap_d = (idx_q == {N{1'b1}});
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: d_d = '0;
        endcase
    end

`ifdef SCAN_DEC_BLANK_EN
    if (DWELL < 2) begin : g_bad_dwell
        $error("SCAN_DEC_BLANK_EN requires DWELL >= 2");
    end
    // Anti-ghosting gap: blank the final cycle of each dwell; idx/wrap are untouched.
    assign d = (state_q == S_SCAN && cnt_q == CNT_LAST) ? '0 : d_q;
`else
    assign d = d_q;
`endif
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
